// File: rtl/clk_mon_10mhz.sv
// Clock monitor for the divided 10 MHz motor-timing clock, sampled in the 50 MHz domain.
// Define CLKMON_PERIOD_CNT_EN to build the good-period counter behind periodCnt.
module clk_mon_10mhz #(
  parameter int unsigned HI_W     = 2,
  parameter int unsigned LO_W     = 3,
  parameter int unsigned TOL      = 0,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TIMEOUT  = 8
) (
  input  logic        clk50mhz,
  input  logic        rst,
  input  logic        clkIn,
  input  logic        clrErr,
  output logic        rise,
  output logic        locked,
  output logic        errHi,
  output logic        errLo,
  output logic        errLoss,
  output logic        fault,
  output logic [15:0] periodCnt
);

  localparam int unsigned WC_W   = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned HI_MIN = (HI_W > TOL) ? HI_W - TOL : 0;
  localparam int unsigned HI_MAX = HI_W + TOL;
  localparam int unsigned LO_MIN = (LO_W > TOL) ? LO_W - TOL : 0;
  localparam int unsigned LO_MAX = LO_W + TOL;
  localparam logic [WC_W-1:0] WC_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQ,
    ST_LOCKED,
    ST_FAULT
  } state_e;

  logic             s1_q, s2_q, s3_q;
  logic [WC_W-1:0]  wc_q, wc_d;
  logic             hi_ok_q, hi_ok_d;
  logic             hi_seen_q, hi_seen_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic             rise_q, locked_q, fault_q;
  logic             err_hi_q, err_hi_d;
  logic             err_lo_q, err_lo_d;
  logic             err_loss_q, err_loss_d;

  logic edge_c, rise_c, fall_c;
  logic hi_good_c, lo_good_c, period_good_c, timeout_c;
  logic set_hi_c, set_lo_c, set_loss_c;

  assign edge_c        = s2_q ^ s3_q;
  assign rise_c        = s2_q & ~s3_q;
  assign fall_c        = ~s2_q & s3_q;
  assign hi_good_c     = (32'(wc_q) >= HI_MIN) && (32'(wc_q) <= HI_MAX);
  assign lo_good_c     = (32'(wc_q) >= LO_MIN) && (32'(wc_q) <= LO_MAX);
  assign period_good_c = rise_c & lo_good_c & hi_ok_q & hi_seen_q;
  assign timeout_c     = !edge_c && (32'(wc_q) == TIMEOUT);

  // Phase-width counter plus the high-width verdict carried to the next rise
  always_comb begin
    wc_d      = (wc_q == WC_MAX) ? wc_q : wc_q + WC_W'(1);
    hi_ok_d   = hi_ok_q;
    hi_seen_d = hi_seen_q;
    if (edge_c) wc_d = WC_W'(1);
    if (fall_c) begin
      hi_ok_d   = hi_good_c;
      hi_seen_d = 1'b1;
    end else if (rise_c) begin
      hi_seen_d = 1'b0;
    end
  end

  // Lock state machine: next state and error set strobes
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    set_hi_c   = 1'b0;
    set_lo_c   = 1'b0;
    set_loss_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_c) begin
          state_d    = ST_ACQ;
          good_cnt_d = '0;
        end
      end
      ST_ACQ: begin
        if (timeout_c) begin
          state_d = ST_IDLE;
        end else if (fall_c && !hi_good_c) begin
          good_cnt_d = '0;
        end else if (rise_c) begin
          if (!period_good_c) begin
            good_cnt_d = '0;
          end else if (32'(good_cnt_q) + 32'd1 >= LOCK_CNT) begin
            state_d    = ST_LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (timeout_c) begin
          set_loss_c = 1'b1;
          state_d    = ST_FAULT;
        end else if (fall_c && !hi_good_c) begin
          set_hi_c = 1'b1;
          state_d  = ST_FAULT;
        end else if (rise_c && !lo_good_c) begin
          set_lo_c = 1'b1;
          state_d  = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (rise_c) begin
          state_d    = ST_ACQ;
          good_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new error outranks a coincident clear
  assign err_hi_d   = (err_hi_q & ~clrErr) | set_hi_c;
  assign err_lo_d   = (err_lo_q & ~clrErr) | set_lo_c;
  assign err_loss_d = (err_loss_q & ~clrErr) | set_loss_c;

  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      wc_q       <= '0;
      hi_ok_q    <= 1'b0;
      hi_seen_q  <= 1'b0;
      state_q    <= ST_IDLE;
      good_cnt_q <= '0;
      rise_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_hi_q   <= 1'b0;
      err_lo_q   <= 1'b0;
      err_loss_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      s1_q       <= clkIn;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      wc_q       <= wc_d;
      hi_ok_q    <= hi_ok_d;
      hi_seen_q  <= hi_seen_d;
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      rise_q     <= rise_c;
      locked_q   <= (state_d == ST_LOCKED);
      err_hi_q   <= err_hi_d;
      err_lo_q   <= err_lo_d;
      err_loss_q <= err_loss_d;
      fault_q    <= err_hi_d | err_lo_d | err_loss_d;
    end
  end

  assign rise    = rise_q;
  assign locked  = locked_q;
  assign errHi   = err_hi_q;
  assign errLo   = err_lo_q;
  assign errLoss = err_loss_q;
  assign fault   = fault_q;

`ifdef CLKMON_PERIOD_CNT_EN
  localparam int unsigned PC_W = 16;
  logic [PC_W-1:0] pc_q, pc_d;

  // Good periods seen while staying locked; restarts on every entry to FAULT
  always_comb begin
    pc_d = pc_q;
    if (state_d == ST_FAULT && state_q != ST_FAULT) begin
      pc_d = '0;
    end else if (state_q == ST_LOCKED && state_d == ST_LOCKED && period_good_c) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign periodCnt = pc_q;
`else
  assign periodCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_clk_mon_10mhz.sv
// Scoreboard bench for clk_mon_10mhz: an event-level model predicts every rise pulse and
// status change (with its cycle stamp); a monitor compares whatever the DUT presents.
module tb_clk_mon_10mhz;

  localparam int HI_W     = 2;
  localparam int LO_W     = 3;
  localparam int TOL      = 0;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 8;

  logic        clk50mhz = 1'b0;
  logic        rst      = 1'b0;
  logic        clkIn    = 1'b0;
  logic        clrErr   = 1'b0;
  logic        rise, locked, errHi, errLo, errLoss, fault;
  logic [15:0] periodCnt;

  int checks   = 0;
  int failures = 0;

  always #10 clk50mhz = ~clk50mhz;

  clk_mon_10mhz dut (
    .clk50mhz (clk50mhz),
    .rst      (rst),
    .clkIn    (clkIn),
    .clrErr   (clrErr),
    .rise     (rise),
    .locked   (locked),
    .errHi    (errHi),
    .errLo    (errLo),
    .errLoss  (errLoss),
    .fault    (fault),
    .periodCnt(periodCnt)
  );

  typedef struct packed {
    logic        rs;
    logic        lk;
    logic        eh;
    logic        el;
    logic        eloss;
    logic        flt;
    logic [15:0] pc;
  } obs_t;

  typedef struct {
    int   stamp;
    obs_t o;
  } exp_t;

  exp_t sb_q[$];
  bit   x_q[$];    // clkIn value seen by posedge t is x_q[t-1]
  int   clr_q[$];  // stamps (posedge numbers) at which clrErr is sampled high

  function automatic bit xs(int k);
    return (k >= 1) ? x_q[k-1] : 1'b0;
  endfunction

  function automatic bit is_clr(int t);
    foreach (clr_q[i]) if (clr_q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_rng(int w, int nom);
    return (w >= nom - TOL) && (w <= nom + TOL);
  endfunction

  // Reference model: walks clkIn transitions and their widths, pushing each expected event
  task automatic model();
    int st;        // 0 idle, 1 acquiring, 2 locked, 3 fault
    int st0;
    int good;
    int last;
    int w;
    int n;
    bit hiok, hiseen, eh, el, eloss, clr, rs, trans, g, lg, pg;
    bit s_hi, s_lo, s_loss;
    logic [15:0] pc;
    obs_t prev, cur, stat;
    exp_t e;
    st = 0; good = 0; last = -1000; hiok = 0; hiseen = 0;
    eh = 0; el = 0; eloss = 0; pc = '0; prev = '0;
    n = x_q.size();
    for (int t = 1; t <= n; t++) begin
      st0 = st; rs = 0; s_hi = 0; s_lo = 0; s_loss = 0;
      clr = is_clr(t);
      trans = (t >= 3) && (xs(t-2) != xs(t-3));
      if (trans) begin
        w = (t - 2) - last;
        if (w > 15) w = 15;
        last = t - 2;
        if (xs(t-2) == 1'b0) begin
          g = in_rng(w, HI_W);
          hiok = g; hiseen = 1;
          if (st == 1 && !g) good = 0;
          else if (st == 2 && !g) begin s_hi = 1; st = 3; end
        end else begin
          lg = in_rng(w, LO_W);
          pg = lg && hiok && hiseen;
          rs = 1; hiseen = 0;
          case (st)
            0, 3: begin st = 1; good = 0; end
            1: begin
              if (pg) begin
                good++;
                if (good >= LOCK_CNT) begin st = 2; good = 0; end
              end else good = 0;
            end
            default: begin
              if (!lg) begin s_lo = 1; st = 3; end
`ifdef CLKMON_PERIOD_CNT_EN
              else if (pg) pc = pc + 16'd1;
`endif
            end
          endcase
        end
      end else if (last >= 1 && t == last + TIMEOUT + 2) begin
        if (st == 1) st = 0;
        else if (st == 2) begin s_loss = 1; st = 3; end
      end
      if (st == 3 && st0 != 3) pc = '0;
      eh    = (eh & ~clr) | s_hi;
      el    = (el & ~clr) | s_lo;
      eloss = (eloss & ~clr) | s_loss;
      cur  = '{rs, (st == 2), eh, el, eloss, (eh | el | eloss), pc};
      stat = cur;
      stat.rs = 1'b0;
      if (rs || stat != prev) begin
        e.stamp = t;
        e.o = cur;
        sb_q.push_back(e);
      end
      prev = stat;
    end
  endtask

  // Monitor: every rise pulse or status change is an output event to be matched
  int   stamp;
  obs_t prev_m, now_m, stat_m;
  exp_t e_m;
  always @(negedge clk50mhz) begin
    if (rst) begin
      stamp  = 0;
      prev_m = '0;
    end else begin
      stamp++;
      now_m  = '{rise, locked, errHi, errLo, errLoss, fault, periodCnt};
      stat_m = now_m;
      stat_m.rs = 1'b0;
      if (now_m.rs || stat_m != prev_m) begin
        while (sb_q.size() > 0 && sb_q[0].stamp < stamp) begin
          e_m = sb_q.pop_front();
          checks++; failures++;
          $display("FAIL missed_event stamp=%0d required=%h got_nothing", e_m.stamp, e_m.o);
        end
        checks++;
        if (sb_q.size() == 0 || sb_q[0].stamp != stamp) begin
          failures++;
          $display("FAIL unexpected_event stamp=%0d got=%h required=no_event", stamp, now_m);
        end else begin
          e_m = sb_q.pop_front();
          if (e_m.o != now_m) begin
            failures++;
            $display("FAIL event stamp=%0d got=%h required=%h", stamp, now_m, e_m.o);
          end
        end
        prev_m = stat_m;
      end
    end
  end

  task automatic do_reset();
    obs_t o;
    rst = 1'b1; clkIn = 1'b0; clrErr = 1'b0;
    #1;
    o = '{rise, locked, errHi, errLo, errLoss, fault, periodCnt};
    checks++;
    if (o != '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", o);
    end
  endtask

  task automatic run_scenario();
    int n;
    exp_t e;
    n = x_q.size();
    model();
    @(negedge clk50mhz); #1;
    rst = 1'b0; clkIn = x_q[0]; clrErr = is_clr(1);
    for (int t = 2; t <= n; t++) begin
      @(negedge clk50mhz);
      clkIn = x_q[t-1]; clrErr = is_clr(t);
    end
    @(negedge clk50mhz); #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      e = sb_q[0];
      $display("FAIL drained pending=%0d first_stamp=%0d required=0", sb_q.size(), e.stamp);
      sb_q.delete();
    end
    do_reset();
    x_q.delete();
    clr_q.delete();
  endtask

  task automatic add_run(bit lvl, int len);
    repeat (len) x_q.push_back(lvl);
  endtask

  task automatic add_per(int hi, int lo, int n);
    repeat (n) begin add_run(1'b1, hi); add_run(1'b0, lo); end
  endtask

  initial begin
    int hi, lo;
    #1 do_reset();

    // nominal divider; ends locked so the following reset lands mid-lock
    add_run(1'b0, 3); add_per(2, 3, 12);
    run_scenario();

    // loss of clock while locked, then reacquire
    add_run(1'b0, 4); add_per(2, 3, 8); add_run(1'b1, 2); add_run(1'b0, 12); add_per(2, 3, 6);
    run_scenario();

    // 3/3 never locks, 2/3 locks, back to 3/3 flags a high error
    add_run(1'b0, 2); add_per(3, 3, 6); add_per(2, 3, 7); add_per(3, 3, 2);
    run_scenario();

    // short low coinciding with clrErr, relock, then an isolated clear
    add_run(1'b0, 3); add_per(2, 3, 7); add_run(1'b1, 2); add_run(1'b0, 2);
    clr_q.push_back(x_q.size() + 3);
    add_per(2, 3, 8);
    clr_q.push_back(x_q.size() - 1);
    run_scenario();

    // one-cycle high glitch while locked
    add_run(1'b0, 3); add_per(2, 3, 6); add_per(1, 3, 1); add_per(2, 3, 2);
    run_scenario();

    // randomised widths, occasional long lows and stray clears
    for (int s = 0; s < 4; s++) begin
      add_run(1'b0, int'($urandom_range(1, 6)));
      for (int i = 0; i < 40; i++) begin
        hi = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 2;
        lo = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 5)) : 3;
        if ($urandom_range(0, 11) == 0) lo = int'($urandom_range(7, 12));
        if ($urandom_range(0, 7) == 0) clr_q.push_back(x_q.size() + int'($urandom_range(1, 6)));
        add_per(hi, lo, 1);
      end
      run_scenario();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_mon_10mhz.md
# clk_mon_10mhz

Monitors the divided 10 MHz motor-timing clock from inside the 50 MHz domain. It synchronises the incoming clock and measures every high and low phase width in 50 MHz cycles, checking each against the nominal 2-high/3-low shape. It declares lock after a run of good periods and raises sticky fault flags for bad widths or loss of clock. It sits beside the 50→10 MHz divider and gates enabling of the 3-phase PWM/commutation logic.

## Interface
Parameters:
- HI_W, default 2: nominal high width, in clk50mhz cycles.
- LO_W, default 3: nominal low width, in clk50mhz cycles.
- TOL, default 0: allowed ± deviation on each width.
- LOCK_CNT, default 4: number of consecutive good periods required for lock; range 1..15.
- TIMEOUT, default 8: number of cycles without an edge that counts as loss of clock; must be greater than max(HI_W, LO_W)+TOL and at most 15.

Ports:
- clk50mhz, in, 1: 50 MHz system clock. All logic is on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- clkIn, in, 1: monitored 10 MHz clock, asynchronous to this block's sampling.
- clrErr, in, 1: one-cycle pulse that clears the sticky error flags.
- rise, out, 1: registered one-cycle pulse per synchronised rising edge of clkIn.
- locked, out, 1: the clock is good.
- errHi, out, 1: sticky; a high width was out of range.
- errLo, out, 1: sticky; a low width was out of range.
- errLoss, out, 1: sticky; a timeout occurred while locked.
- fault, out, 1: errHi | errLo | errLoss (registered OR).
- periodCnt, out, 16: count of good periods while locked; see Configuration.

## Operation
- Synchroniser: clkIn → s1 → s2. s3 holds the previous s2. An edge is a cycle where s2 != s3.
- Width counter wc (4 bits, saturating at 15):
  - On an edge cycle, wc loads 1.
  - Otherwise wc increments.
  - On a falling edge, the pre-load wc value is the high width. On a rising edge, it is the low width.
- A width is good when it lies in [W−TOL, W+TOL].
- A period is good at a rising edge when the low width just ended is good and the high width latched at the preceding falling edge was good and was seen since the last rise.
- State machine:
  - IDLE (reset state):
    - First rising edge → ACQ, with goodCnt=0. The partial low width is ignored.
  - ACQ:
    - Good period → goodCnt+1. When goodCnt reaches LOCK_CNT → LOCKED.
    - Bad width → goodCnt=0, stay in ACQ. No error flag is set.
    - wc reaches TIMEOUT → IDLE.
  - LOCKED:
    - Bad high width → set errHi, go to FAULT.
    - Bad low width → set errLo, go to FAULT.
    - wc reaches TIMEOUT → set errLoss, go to FAULT.
  - FAULT:
    - Next rising edge → ACQ, with goodCnt=0.
- locked=1 only in the LOCKED state.
- Sticky flags:
  - clrErr clears all flags.
  - When an error and clrErr occur in the same cycle, the error wins.
- Simultaneous edge and timeout cannot occur, because wc reloads on the edge.

## Timing
- Reset values: rise=0, locked=0, errHi=0, errLo=0, errLoss=0, fault=0, periodCnt=0, state=IDLE, wc=0, s1=s2=s3=0.
- Reset takes effect immediately, including mid-lock.
- Latency from clkIn rising to rise=1: rise is high in the cycle after the third clk50mhz edge that samples clkIn high. It lasts exactly one cycle.
- locked asserts in the same cycle as the rise pulse of the LOCK_CNT-th good period.
  - With the defaults and the nominal input: the 5th rise pulse after reset, 20 cycles after the first.
- Error flags, fault and the drop of locked all register in the cycle after the offending edge or timeout is detected.
- Nominal input period is 5 cycles. wc never exceeds 3 in normal operation.

## Configuration
- CLKMON_PERIOD_CNT_EN defined:
  - periodCnt increments by 1 on each good-period rise while LOCKED.
  - It wraps from 0xFFFF to 0.
  - It clears on reset and on entry to FAULT.
- CLKMON_PERIOD_CNT_EN undefined:
  - periodCnt is tied to 0. The port remains present.
  - The counter logic is not synthesised.

## Test plan
- Nominal divider model (2 high/3 low, clkIn changing on negedge) → locked=1 on the 5th rise pulse; fault stays 0. With the macro defined, periodCnt increases by 1 every 5 cycles.
- While locked, hold clkIn low → errLoss=1, fault=1 and locked=0 one cycle after wc reaches 8. The next rising edge returns the block to ACQ, and it relocks after 4 good periods.
- A 3-high/3-low input → never locks and no flags are set. Switching to 2/3 → locks after 4 periods. Switching back to 3/3 while locked → errHi=1.
- Assert clrErr in the same cycle that errLo is being set → errLo remains 1. A later isolated clrErr → all flags and fault return to 0.
- Assert rst mid-lock → all outputs are 0 immediately. After release, the block relocks on the 5th rise.
- A single 1-cycle glitch high pulse while locked → errHi=1 and locked=0.
